// File: rtl/int_root_unit.sv
// int_root_unit: iterative integer square / cube root with remainder.
// One result bit is resolved per clock; the sqrt path uses restoring bit-pair
// subtraction and the cube path uses the (3y(y+1)+1) << s trial subtrahend.
module int_root_unit #(
  parameter int W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [W-1:0]         x_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [(W+1)/2-1:0]   y_bo,
  output logic [W-1:0]         rem_bo
);

  localparam int RW  = (W + 1) / 2;
  localparam int NSQ = (W + 1) / 2;
  localparam int NCB = (W + 2) / 3;

  typedef enum logic {IDLE, WORK} state_t;

  state_t          state, state_nx;
  logic            mode, mode_nx;
  logic [5:0]      cnt, cnt_nx;
  logic [W-1:0]    x_r, x_nx;
  logic [W-1:0]    y_r, y_nx;
  logic            done_nx;
  logic [RW-1:0]   yo_nx;
  logic [W-1:0]    rem_nx;

  logic [5:0]      cm1;
  logic [W-1:0]    m;
  logic [W-1:0]    sb;
  logic [W-1:0]    ysh;
  logic [W-1:0]    yc;
  logic [7:0]      s3;
  logic [63:0]     bc;

  assign busy_o = (state == WORK);

  // State, working registers and result registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      mode   <= 1'b0;
      cnt    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      done_o <= 1'b0;
      y_bo   <= '0;
      rem_bo <= '0;
    end else begin
      state  <= state_nx;
      mode   <= mode_nx;
      cnt    <= cnt_nx;
      x_r    <= x_nx;
      y_r    <= y_nx;
      done_o <= done_nx;
      y_bo   <= yo_nx;
      rem_bo <= rem_nx;
    end
  end

  // Next-state logic and one root iteration per WORK cycle.
  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    cnt_nx   = cnt;
    x_nx     = x_r;
    y_nx     = y_r;
    done_nx  = 1'b0;
    yo_nx    = y_bo;
    rem_nx   = rem_bo;
    cm1      = cnt - 6'd1;
    m        = '0;
    sb       = '0;
    ysh      = '0;
    yc       = '0;
    s3       = '0;
    bc       = '0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = WORK;
          x_nx     = x_bi;
          mode_nx  = mode_i;
          y_nx     = '0;
          cnt_nx   = mode_i ? 6'(NCB) : 6'(NSQ);
        end
      end
      WORK: begin
        if (!mode) begin
          // Bit-pair weight derived from the remaining count instead of a separate m register.
          m   = W'(1) << {cm1, 1'b0};
          sb  = y_r | m;
          ysh = y_r >> 1;
          if (x_r >= sb) begin
            x_nx = x_r - sb;
            ysh  = ysh | m;
          end
          y_nx = ysh;
        end else begin
          // Trial subtrahend kept at 64 bits so values >= 2^W are always rejected.
          yc = y_r << 1;
          s3 = {2'b00, cm1} * 8'd3;
          bc = ((64'd3 * 64'(yc) * (64'(yc) + 64'd1)) + 64'd1) << s3;
          if (bc <= 64'(x_r)) begin
            x_nx = x_r - W'(bc);
            yc   = yc + W'(1);
          end
          y_nx = yc;
        end
        cnt_nx = cnt - 6'd1;
        if (cnt == 6'd1) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          yo_nx    = y_nx[RW-1:0];
          rem_nx   = x_nx;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
